// File: rtl/h_u_bam_seq.sv
// h_u_bam_seq: sequential broken-array multiplier.
// Accumulates one partial-product row per cycle. Rows below the horizontal
// break and partial products below the vertical break are left out.
module h_u_bam_seq #(
  parameter int unsigned N  = 8,
  parameter int unsigned HW = $clog2(N + 1),
  parameter int unsigned VW = $clog2(2 * N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N-1:0]      a,
  input  logic [N-1:0]      b,
  input  logic [HW-1:0]     cfg_h,
  input  logic [VW-1:0]     cfg_v,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*N-1:0]    out
);

  localparam int unsigned OW = 2 * N;
  // Wide enough to hold cfg_v, j and N without wrap in the mask comparison.
  localparam int unsigned DW = ((HW > VW) ? HW : VW) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [HW-1:0]   j_q;
  logic [N-1:0]    a_q;
  logic [N-1:0]    b_q;
  logic [VW-1:0]   v_q;
  logic [OW-1:0]   acc_q;

  logic [DW-1:0]   v_ext;
  logic [DW-1:0]   j_ext;
  logic [DW-1:0]   diff;
  logic [N-1:0]    b_sh;
  logic [N-1:0]    row;
  logic [OW-1:0]   addend;
  logic [OW-1:0]   acc_sum;
  logic            row_live;
  logic            last_row;

  // Current row's contribution: a masked to bits i >= cfg_v - j, shifted by j.
  always_comb begin
    v_ext    = DW'(v_q);
    j_ext    = DW'(j_q);
    diff     = v_ext - j_ext;
    b_sh     = b_q >> j_q;
    row      = '0;
    addend   = '0;
    row_live = (j_ext < DW'(N));
    last_row = (j_ext >= DW'(N - 1));
    if (v_ext <= j_ext) begin
      row = a_q;
    end else if (diff >= DW'(N)) begin
      row = '0;
    end else begin
      row = a_q & ({N{1'b1}} << diff);
    end
    if (row_live && b_sh[0]) begin
      addend = OW'(row) << j_q;
    end
    acc_sum = acc_q + addend;
  end

  // Control FSM with registered handshake flags, accumulator and result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out       <= '0;
      acc_q     <= '0;
      j_q       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      v_q       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q      <= a;
            b_q      <= b;
            v_q      <= cfg_v;
            j_q      <= (cfg_h > HW'(N)) ? HW'(N) : cfg_h;
            acc_q    <= '0;
            in_ready <= 1'b0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          acc_q <= acc_sum;
          if (last_row) begin
            out       <= acc_sum;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            j_q <= j_q + HW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
